// File: rtl/regfile_sb.sv
// Register file with configurable read ports, one bypassed write port, a
// pending-write scoreboard and a post-reset clear sweep. Optional macro:
// REGFILE_SB_BYPASS_EN enables same-cycle write-to-read forwarding.
module regfile_sb #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int NRD   = 2,
    localparam int AW   = $clog2(NREGS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                stall,
    input  logic                wr_en,
    input  logic [AW-1:0]       wr_addr,
    input  logic [XLEN-1:0]     wr_data,
    input  logic                rsv_en,
    input  logic [AW-1:0]       rsv_addr,
    input  logic [NRD*AW-1:0]   rs_addr,
    output logic [NRD*XLEN-1:0] rs_data,
    output logic [NRD-1:0]      rs_busy,
    output logic                ready
);

    typedef enum logic {
        INIT,
        RUN
    } state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   clr_idx_q, clr_idx_d;
    logic [NREGS-1:0] busy_q, busy_d;
    logic            ready_q, ready_d;

    logic [XLEN-1:0] mem [NREGS];
    logic            mem_we;
    logic [AW-1:0]   mem_waddr;
    logic [XLEN-1:0] mem_wdata;

    logic run;
    logic wr_fire;
    logic rsv_fire;

    assign run      = (state_q == RUN);
    assign wr_fire  = run & wr_en & ~stall & (wr_addr != '0);
    assign rsv_fire = run & rsv_en & ~stall & (rsv_addr != '0);
    assign ready    = ready_q;

    // The sweep advances every cycle regardless of stall, so it always takes NREGS cycles.
    always_comb begin
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        ready_d   = ready_q;
        if (state_q == INIT) begin
            clr_idx_d = clr_idx_q + 1'b1;
            if (clr_idx_q == AW'(NREGS - 1)) begin
                state_d = RUN;
                ready_d = 1'b1;
            end
        end else begin
            ready_d = 1'b1;
        end
    end

    // Reservation is applied after the write so a newer producer keeps the register busy.
    always_comb begin
        busy_d = busy_q;
        if (wr_fire) begin
            busy_d[wr_addr] = 1'b0;
        end
        if (rsv_fire) begin
            busy_d[rsv_addr] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = clr_idx_q;
        mem_wdata = '0;
        if (!run) begin
            mem_we = 1'b1;
        end else if (wr_fire) begin
            mem_we    = 1'b1;
            mem_waddr = wr_addr;
            mem_wdata = wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= INIT;
            clr_idx_q <= '0;
            busy_q    <= '0;
            ready_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            clr_idx_q <= clr_idx_d;
            busy_q    <= busy_d;
            ready_q   <= ready_d;
        end
    end

    // Storage has no reset; the INIT sweep zeroes every entry instead.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [AW-1:0] addr;
        logic          hit;

        assign addr = rs_addr[k*AW +: AW];
`ifdef REGFILE_SB_BYPASS_EN
        assign hit = wr_fire & (wr_addr == addr);
`else
        assign hit = 1'b0;
`endif
        assign rs_data[k*XLEN +: XLEN] = (!run || addr == '0) ? '0 :
                                         hit ? wr_data : mem[addr];
        assign rs_busy[k] = run & (addr != '0) & busy_q[addr] & ~hit;
    end

endmodule

// File: tb/tb_regfile_sb.sv
// Directed testbench for regfile_sb: default configuration plus a
// 16-register, 3-read-port instance used for the sweep/reset checks.
module tb_regfile_sb;

    localparam int XLEN   = 32;
    localparam int NREGS  = 32;
    localparam int NRD    = 2;
    localparam int AW     = 5;
    localparam int NREGS2 = 16;
    localparam int NRD2   = 3;
    localparam int AW2    = 4;

`ifdef REGFILE_SB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                rst;
    logic                stall;
    logic                wr_en;
    logic [AW-1:0]       wr_addr;
    logic [XLEN-1:0]     wr_data;
    logic                rsv_en;
    logic [AW-1:0]       rsv_addr;
    logic [NRD*AW-1:0]   rs_addr;
    logic [NRD*XLEN-1:0] rs_data;
    logic [NRD-1:0]      rs_busy;
    logic                ready;

    logic                 rst2;
    logic                 stall2;
    logic                 wr_en2;
    logic [AW2-1:0]       wr_addr2;
    logic [XLEN-1:0]      wr_data2;
    logic                 rsv_en2;
    logic [AW2-1:0]       rsv_addr2;
    logic [NRD2*AW2-1:0]  rs_addr2;
    logic [NRD2*XLEN-1:0] rs_data2;
    logic [NRD2-1:0]      rs_busy2;
    logic                 ready2;

    int checks   = 0;
    int failures = 0;

    regfile_sb #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD)) u_dut (
        .clk(clk), .rst(rst), .stall(stall),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr),
        .rs_addr(rs_addr), .rs_data(rs_data), .rs_busy(rs_busy),
        .ready(ready)
    );

    regfile_sb #(.XLEN(XLEN), .NREGS(NREGS2), .NRD(NRD2)) u_dut2 (
        .clk(clk), .rst(rst2), .stall(stall2),
        .wr_en(wr_en2), .wr_addr(wr_addr2), .wr_data(wr_data2),
        .rsv_en(rsv_en2), .rsv_addr(rsv_addr2),
        .rs_addr(rs_addr2), .rs_data(rs_data2), .rs_busy(rs_busy2),
        .ready(ready2)
    );

    task drive_idle;
        stall    = 1'b0;
        wr_en    = 1'b0;
        wr_addr  = '0;
        wr_data  = '0;
        rsv_en   = 1'b0;
        rsv_addr = '0;
        rs_addr  = '0;
    endtask

    task drive_idle2;
        stall2    = 1'b0;
        wr_en2    = 1'b0;
        wr_addr2  = '0;
        wr_data2  = '0;
        rsv_en2   = 1'b0;
        rsv_addr2 = '0;
        rs_addr2  = '0;
    endtask

    task test_reset;
        drive_idle();
        stall   = 1'b1;
        wr_en   = 1'b1;
        wr_addr = 5'd5;
        wr_data = 32'h0000DEAD;
        rs_addr = {5'd0, 5'd5};
        rst     = 1'b1;
        @(negedge clk);
        #1;
        checks++;
        if (ready !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_ready got=%0b exp=0", ready);
        end
        checks++;
        if (rs_busy !== 2'b00) begin
            failures++;
            $display("[TB] FAIL reset_busy got=%b exp=00", rs_busy);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < NREGS; i++) begin
            #1;
            checks++;
            if (ready !== 1'b0) begin
                failures++;
                $display("[TB] FAIL sweep_ready cyc=%0d got=%0b exp=0", i, ready);
            end
            checks++;
            if (rs_data !== 64'h0) begin
                failures++;
                $display("[TB] FAIL sweep_rdata cyc=%0d got=%h exp=0", i, rs_data);
            end
            @(negedge clk);
        end
        #1;
        checks++;
        if (ready !== 1'b1) begin
            failures++;
            $display("[TB] FAIL sweep_done_ready got=%0b exp=1", ready);
        end
        checks++;
        if (rs_data[31:0] !== 32'h0) begin
            failures++;
            $display("[TB] FAIL sweep_r5 got=%h exp=0", rs_data[31:0]);
        end
        drive_idle();
    endtask

    task test_write_read;
        @(negedge clk);
        drive_idle();
        wr_en   = 1'b1;
        wr_addr = 5'd3;
        wr_data = 32'h12345678;
        rs_addr = {5'd0, 5'd3};
        #1;
        checks++;
        if (rs_data[31:0] !== (BYP ? 32'h12345678 : 32'h0)) begin
            failures++;
            $display("[TB] FAIL wr_same_cycle got=%h exp=%h", rs_data[31:0],
                     BYP ? 32'h12345678 : 32'h0);
        end
        @(negedge clk);
        wr_en = 1'b0;
        #1;
        checks++;
        if (rs_data[31:0] !== 32'h12345678) begin
            failures++;
            $display("[TB] FAIL wr_next_cycle got=%h exp=12345678", rs_data[31:0]);
        end
    endtask

    task test_reg0;
        @(negedge clk);
        drive_idle();
        wr_en    = 1'b1;
        wr_addr  = 5'd0;
        wr_data  = 32'hFFFFFFFF;
        rsv_en   = 1'b1;
        rsv_addr = 5'd0;
        rs_addr  = {5'd0, 5'd0};
        #1;
        checks++;
        if (rs_data !== 64'h0) begin
            failures++;
            $display("[TB] FAIL r0_data_now got=%h exp=0", rs_data);
        end
        checks++;
        if (rs_busy !== 2'b00) begin
            failures++;
            $display("[TB] FAIL r0_busy_now got=%b exp=00", rs_busy);
        end
        @(negedge clk);
        drive_idle();
        #1;
        checks++;
        if (rs_data !== 64'h0) begin
            failures++;
            $display("[TB] FAIL r0_data_after got=%h exp=0", rs_data);
        end
        checks++;
        if (rs_busy !== 2'b00) begin
            failures++;
            $display("[TB] FAIL r0_busy_after got=%b exp=00", rs_busy);
        end
    endtask

    task test_scoreboard;
        @(negedge clk);
        drive_idle();
        rsv_en   = 1'b1;
        rsv_addr = 5'd7;
        rs_addr  = {5'd7, 5'd7};
        #1;
        checks++;
        if (rs_busy !== 2'b00) begin
            failures++;
            $display("[TB] FAIL rsv_before_edge got=%b exp=00", rs_busy);
        end
        @(negedge clk);
        rsv_en = 1'b0;
        #1;
        checks++;
        if (rs_busy !== 2'b11) begin
            failures++;
            $display("[TB] FAIL rsv_set got=%b exp=11", rs_busy);
        end
        @(negedge clk);
        #1;
        checks++;
        if (rs_busy !== 2'b11) begin
            failures++;
            $display("[TB] FAIL rsv_hold got=%b exp=11", rs_busy);
        end
        @(negedge clk);
        wr_en    = 1'b1;
        wr_addr  = 5'd7;
        wr_data  = 32'hA5;
        rsv_en   = 1'b1;
        rsv_addr = 5'd7;
        #1;
        checks++;
        if (rs_busy[0] !== !BYP) begin
            failures++;
            $display("[TB] FAIL wr_rsv_busy_now got=%0b exp=%0b", rs_busy[0], !BYP);
        end
        checks++;
        if (rs_data[31:0] !== (BYP ? 32'hA5 : 32'h0)) begin
            failures++;
            $display("[TB] FAIL wr_rsv_data_now got=%h exp=%h", rs_data[31:0],
                     BYP ? 32'hA5 : 32'h0);
        end
        @(negedge clk);
        wr_en  = 1'b0;
        rsv_en = 1'b0;
        #1;
        checks++;
        if (rs_busy !== 2'b11) begin
            failures++;
            $display("[TB] FAIL rsv_wins got=%b exp=11", rs_busy);
        end
        checks++;
        if (rs_data[31:0] !== 32'hA5) begin
            failures++;
            $display("[TB] FAIL rsv_wins_data got=%h exp=a5", rs_data[31:0]);
        end
        @(negedge clk);
        wr_en   = 1'b1;
        wr_addr = 5'd7;
        wr_data = 32'hA5;
        #1;
        checks++;
        if (rs_busy[0] !== !BYP) begin
            failures++;
            $display("[TB] FAIL wr_clear_now got=%0b exp=%0b", rs_busy[0], !BYP);
        end
        @(negedge clk);
        wr_en = 1'b0;
        #1;
        checks++;
        if (rs_busy !== 2'b00) begin
            failures++;
            $display("[TB] FAIL wr_cleared got=%b exp=00", rs_busy);
        end
        checks++;
        if (rs_data[63:32] !== 32'hA5) begin
            failures++;
            $display("[TB] FAIL wr_cleared_data got=%h exp=a5", rs_data[63:32]);
        end
    endtask

    task test_stall;
        @(negedge clk);
        drive_idle();
        stall    = 1'b1;
        wr_en    = 1'b1;
        wr_addr  = 5'd9;
        wr_data  = 32'h55;
        rsv_en   = 1'b1;
        rsv_addr = 5'd10;
        rs_addr  = {5'd10, 5'd9};
        #1;
        checks++;
        if (rs_data[31:0] !== 32'h0) begin
            failures++;
            $display("[TB] FAIL stall_no_bypass got=%h exp=0", rs_data[31:0]);
        end
        checks++;
        if (rs_busy !== 2'b00) begin
            failures++;
            $display("[TB] FAIL stall_busy_now got=%b exp=00", rs_busy);
        end
        @(negedge clk);
        stall  = 1'b0;
        wr_en  = 1'b0;
        rsv_en = 1'b0;
        #1;
        checks++;
        if (rs_data[31:0] !== 32'h0) begin
            failures++;
            $display("[TB] FAIL stall_no_write got=%h exp=0", rs_data[31:0]);
        end
        checks++;
        if (rs_busy !== 2'b00) begin
            failures++;
            $display("[TB] FAIL stall_no_rsv got=%b exp=00", rs_busy);
        end
        @(negedge clk);
        wr_en  = 1'b1;
        rsv_en = 1'b1;
        #1;
        checks++;
        if (rs_data[31:0] !== (BYP ? 32'h55 : 32'h0)) begin
            failures++;
            $display("[TB] FAIL unstall_bypass got=%h exp=%h", rs_data[31:0],
                     BYP ? 32'h55 : 32'h0);
        end
        @(negedge clk);
        wr_en  = 1'b0;
        rsv_en = 1'b0;
        #1;
        checks++;
        if (rs_data[31:0] !== 32'h55) begin
            failures++;
            $display("[TB] FAIL unstall_write got=%h exp=55", rs_data[31:0]);
        end
        checks++;
        if (rs_busy !== 2'b10) begin
            failures++;
            $display("[TB] FAIL unstall_rsv got=%b exp=10", rs_busy);
        end
    endtask

    task test_back_to_back;
        @(negedge clk);
        drive_idle();
        rs_addr = {5'd2, 5'd1};
        wr_en   = 1'b1;
        wr_addr = 5'd1;
        wr_data = 32'h11;
        #1;
        checks++;
        if (rs_data !== {32'h0, BYP ? 32'h11 : 32'h0}) begin
            failures++;
            $display("[TB] FAIL b2b_1 got=%h", rs_data);
        end
        @(negedge clk);
        wr_addr = 5'd2;
        wr_data = 32'h22;
        #1;
        checks++;
        if (rs_data !== {BYP ? 32'h22 : 32'h0, 32'h11}) begin
            failures++;
            $display("[TB] FAIL b2b_2 got=%h", rs_data);
        end
        @(negedge clk);
        wr_addr = 5'd1;
        wr_data = 32'h33;
        #1;
        checks++;
        if (rs_data !== {32'h22, BYP ? 32'h33 : 32'h11}) begin
            failures++;
            $display("[TB] FAIL b2b_3 got=%h", rs_data);
        end
        @(negedge clk);
        wr_en = 1'b0;
        #1;
        checks++;
        if (rs_data !== {32'h22, 32'h33}) begin
            failures++;
            $display("[TB] FAIL b2b_final got=%h exp=%h", rs_data, {32'h22, 32'h33});
        end
    endtask

    task test_mid_sweep_reset;
        @(negedge clk);
        drive_idle();
        rs_addr = {5'd10, 5'd9};
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if (ready !== 1'b0) begin
            failures++;
            $display("[TB] FAIL mid_rst_ready got=%0b exp=0", ready);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < NREGS; i++) begin
            #1;
            checks++;
            if (ready !== 1'b0) begin
                failures++;
                $display("[TB] FAIL mid_sweep_ready cyc=%0d got=%0b exp=0", i, ready);
            end
            @(negedge clk);
        end
        #1;
        checks++;
        if (ready !== 1'b1) begin
            failures++;
            $display("[TB] FAIL mid_sweep_done got=%0b exp=1", ready);
        end
        checks++;
        if (rs_data[31:0] !== 32'h0) begin
            failures++;
            $display("[TB] FAIL mid_sweep_r9 got=%h exp=0", rs_data[31:0]);
        end
        checks++;
        if (rs_busy !== 2'b00) begin
            failures++;
            $display("[TB] FAIL mid_sweep_busy got=%b exp=00", rs_busy);
        end
    endtask

    task test_small_config;
        @(negedge clk);
        drive_idle2();
        rst2 = 1'b0;
        for (int i = 0; i < NREGS2; i++) begin
            #1;
            checks++;
            if (ready2 !== 1'b0) begin
                failures++;
                $display("[TB] FAIL small_sweep_ready cyc=%0d got=%0b exp=0", i, ready2);
            end
            @(negedge clk);
        end
        #1;
        checks++;
        if (ready2 !== 1'b1) begin
            failures++;
            $display("[TB] FAIL small_sweep_done got=%0b exp=1", ready2);
        end
        @(negedge clk);
        rs_addr2 = {4'd1, 4'd15, 4'd8};
        wr_en2   = 1'b1;
        wr_addr2 = 4'd8;
        wr_data2 = 32'h77;
        #1;
        checks++;
        if (rs_data2[31:0] !== (BYP ? 32'h77 : 32'h0)) begin
            failures++;
            $display("[TB] FAIL small_wr_now got=%h", rs_data2[31:0]);
        end
        @(negedge clk);
        wr_en2    = 1'b0;
        rsv_en2   = 1'b1;
        rsv_addr2 = 4'd15;
        #1;
        checks++;
        if (rs_data2 !== {32'h0, 32'h0, 32'h77}) begin
            failures++;
            $display("[TB] FAIL small_wr_after got=%h", rs_data2);
        end
        @(negedge clk);
        rsv_en2 = 1'b0;
        #1;
        checks++;
        if (rs_busy2 !== 3'b010) begin
            failures++;
            $display("[TB] FAIL small_rsv got=%b exp=010", rs_busy2);
        end
        rst2 = 1'b1;
        @(negedge clk);
        rst2 = 1'b0;
        repeat (10) @(negedge clk);
        rst2 = 1'b1;
        #1;
        checks++;
        if (rs_busy2 !== 3'b000 || ready2 !== 1'b0) begin
            failures++;
            $display("[TB] FAIL small_mid_rst busy=%b ready=%0b exp=000/0", rs_busy2, ready2);
        end
        @(negedge clk);
        rst2 = 1'b0;
        for (int i = 0; i < NREGS2; i++) begin
            #1;
            checks++;
            if (ready2 !== 1'b0) begin
                failures++;
                $display("[TB] FAIL small_mid_ready cyc=%0d got=%0b exp=0", i, ready2);
            end
            @(negedge clk);
        end
        #1;
        checks++;
        if (ready2 !== 1'b1) begin
            failures++;
            $display("[TB] FAIL small_mid_done got=%0b exp=1", ready2);
        end
        checks++;
        if (rs_data2 !== 96'h0) begin
            failures++;
            $display("[TB] FAIL small_mid_cleared got=%h exp=0", rs_data2);
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog timeout");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        rst  = 1'b1;
        rst2 = 1'b1;
        drive_idle();
        drive_idle2();
        test_reset();
        test_write_read();
        test_reg0();
        test_scoreboard();
        test_stall();
        test_back_to_back();
        test_mid_sweep_reset();
        test_small_config();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
